// File: rtl/ofs_plat_host_mem_rd_rsp_reorder_if.sv
// Handshake bundle for the host-memory read-response reorder buffer.
// Groups the allocate, response and ordered-output streams.
interface ofs_plat_host_mem_rd_rsp_reorder_if #(
    parameter int N_ENTRIES  = 64,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 8
);
    localparam int IDX_W = $clog2(N_ENTRIES);

    logic                  alloc_valid;
    logic [1:0]            alloc_len;
    logic [USER_WIDTH-1:0] alloc_user;
    logic                  alloc_ready;
    logic [IDX_W-1:0]      alloc_idx;

    logic                  rsp_valid;
    logic [IDX_W-1:0]      rsp_idx;
    logic [1:0]            rsp_cl_num;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [USER_WIDTH-1:0] out_user;
    logic                  out_sop;
    logic                  out_eop;

    modport master (
        output alloc_valid, alloc_len, alloc_user,
        input  alloc_ready, alloc_idx,
        output rsp_valid, rsp_idx, rsp_cl_num, rsp_data,
        input  out_valid, out_data, out_user, out_sop, out_eop,
        output out_ready
    );

    modport slave (
        input  alloc_valid, alloc_len, alloc_user,
        output alloc_ready, alloc_idx,
        input  rsp_valid, rsp_idx, rsp_cl_num, rsp_data,
        output out_valid, out_data, out_user, out_sop, out_eop,
        input  out_ready
    );
endinterface

// File: rtl/ofs_plat_host_mem_rd_rsp_reorder.sv
// Read-response reorder buffer: slots are allocated in request order,
// filled out of order by CCI-P responses, and drained in order.
module ofs_plat_host_mem_rd_rsp_reorder #(
    parameter int N_ENTRIES  = 64,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    ofs_plat_host_mem_rd_rsp_reorder_if.slave bus
);
    localparam int IDX_W = $clog2(N_ENTRIES);

    typedef logic [IDX_W:0]   ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    ptr_t head;
    ptr_t tail;
    ptr_t used;
    ptr_t free_cnt;
    idx_t head_idx;
    idx_t tail_idx;

    logic [N_ENTRIES-1:0] valid;
    logic [N_ENTRIES-1:0] valid_nxt;
    logic [N_ENTRIES-1:0] sop_mem;
    logic [N_ENTRIES-1:0] eop_mem;
    logic [USER_WIDTH-1:0] user_mem [N_ENTRIES];
    logic [DATA_WIDTH-1:0] data_mem [N_ENTRIES];

    logic [2:0] alloc_lines;
    logic       alloc_fire;
    idx_t       rsp_slot;
    idx_t       rsp_off;
    logic       load;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [USER_WIDTH-1:0] out_user_q;
    logic                  out_sop_q;
    logic                  out_eop_q;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign used     = tail - head;
    assign free_cnt = ptr_t'(N_ENTRIES) - used;

    // Room for a worst-case 4-line request, independent of alloc_len.
    assign bus.alloc_ready = (free_cnt >= ptr_t'(4));
    assign bus.alloc_idx   = tail_idx;
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    // Decode cl_len; the illegal 2'b10 code is treated as 4 lines.
    always_comb begin
        alloc_lines = 3'd4;
        case (bus.alloc_len)
            2'b00:   alloc_lines = 3'd1;
            2'b01:   alloc_lines = 3'd2;
            default: alloc_lines = 3'd4;
        endcase
    end

    assign rsp_slot = bus.rsp_idx + {{(IDX_W-2){1'b0}}, bus.rsp_cl_num};
    assign rsp_off  = rsp_slot - head_idx;

    assign load = valid[head_idx] && (!out_valid_q || bus.out_ready);

    // Slot valid bits: set by an arriving line, cleared when the head drains.
    always_comb begin
        valid_nxt = valid;
        if (load) begin
            valid_nxt[head_idx] = 1'b0;
        end
        if (bus.rsp_valid) begin
            valid_nxt[rsp_slot] = 1'b1;
        end
    end

    // Slot valid register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            valid <= valid_nxt;
        end
    end

    // Head advances per loaded line, tail per accepted request length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load) begin
                head <= head + ptr_t'(1);
            end
            if (alloc_fire) begin
                tail <= tail + {{(IDX_W-2){1'b0}}, alloc_lines};
            end
        end
    end

    // Per-slot metadata and line storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            user_mem[tail_idx] <= bus.alloc_user;
            for (int i = 0; i < 4; i++) begin
                if (i < int'(alloc_lines)) begin
                    sop_mem[tail_idx + idx_t'(i)] <= (i == 0);
                    eop_mem[tail_idx + idx_t'(i)] <=
                        (i == int'(alloc_lines) - 1);
                end
            end
        end
        if (bus.rsp_valid) begin
            data_mem[rsp_slot] <= bus.rsp_data;
        end
    end

    // Single-flit output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_mem[head_idx];
            out_sop_q   <= sop_mem[head_idx];
            out_eop_q   <= eop_mem[head_idx];
            out_user_q  <= sop_mem[head_idx] ? user_mem[head_idx] : '0;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_user  = out_user_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;

    // Flag upstream protocol violations in simulation.
    always @(posedge clk) begin
        if (reset_n) begin
            if (bus.alloc_valid) begin
                assert (bus.alloc_len != 2'b10)
                else $error("reorder: illegal alloc_len 2'b10");
            end
            if (bus.rsp_valid) begin
                assert (!valid[rsp_slot] && ({1'b0, rsp_off} < used))
                else $error("reorder: bad response slot %0d", rsp_slot);
            end
        end
    end
endmodule

// File: tb/tb_ofs_plat_host_mem_rd_rsp_reorder.sv
// Scoreboard bench for the read-response reorder buffer.
// Eight slots so that full and wrap-around are easy to reach.
module tb_ofs_plat_host_mem_rd_rsp_reorder;
    localparam int N  = 8;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          sop;
        logic          eop;
    } line_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ofs_plat_host_mem_rd_rsp_reorder_if #(
        .N_ENTRIES(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) bus ();

    ofs_plat_host_mem_rd_rsp_reorder #(
        .N_ENTRIES(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    line_t         exp_q[$];
    logic [DW-1:0] sd[N];
    int n_cmp = 0;
    int n_bad = 0;
    int gseq  = 0;
    int mtail = 0;

    task automatic tick();
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        bus.rsp_valid   = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] len, input logic [UW-1:0] user);
        int n;
        line_t e;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        bus.alloc_valid = 1'b1;
        bus.alloc_len   = len;
        bus.alloc_user  = user;
        for (int i = 0; i < n; i++) begin
            gseq++;
            e.data = {32'hD000_0000 | 32'(gseq), 32'(gseq) * 32'h9E37_79B9};
            e.user = (i == 0) ? user : '0;
            e.sop  = (i == 0);
            e.eop  = (i == n - 1);
            sd[(mtail + i) % N] = e.data;
            exp_q.push_back(e);
        end
        mtail = mtail + n;
    endtask

    task automatic set_rsp(input int idx, input int cl);
        bus.rsp_valid  = 1'b1;
        bus.rsp_idx    = IW'(idx);
        bus.rsp_cl_num = 2'(cl);
        bus.rsp_data   = sd[(idx + cl) % N];
    endtask

    task automatic apply_reset();
        bus.alloc_valid = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.out_ready   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        mtail = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.out_sop, bus.out_eop} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_out got=%b exp=000",
                     {bus.out_valid, bus.out_sop, bus.out_eop});
        end
        n_cmp++;
        if (bus.out_user !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_user got=%h exp=00", bus.out_user);
        end
        n_cmp++;
        if (bus.alloc_idx !== 3'd0 || bus.alloc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_alloc got idx=%0d rdy=%b exp idx=0 rdy=1",
                     bus.alloc_idx, bus.alloc_ready);
        end
        apply_reset();
    endtask

    task automatic test_single();
        line_t e;
        int got;
        set_alloc(2'b00, 8'h5A);
        n_cmp++;
        if (bus.alloc_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL single_idx got=%0d exp=0", bus.alloc_idx);
        end
        tick();
        set_rsp(0, 0);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early got=%b exp=0", bus.out_valid);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency got=%b exp=1", bus.out_valid);
        end
        got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 1; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL single_line got=%h exp=%h",
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain got=%0d valid=%b exp 1 line then valid=0",
                     got, bus.out_valid);
        end
    endtask

    task automatic test_order();
        line_t e;
        int got;
        int ri[6] = '{4, 0, 0, 4, 0, 0};
        int rc[6] = '{1, 3, 0, 0, 2, 1};
        apply_reset();
        set_alloc(2'b11, 8'hA1);
        n_cmp++;
        if (bus.alloc_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL order_idx0 got=%0d exp=0", bus.alloc_idx);
        end
        tick();
        set_alloc(2'b01, 8'hB2);
        n_cmp++;
        if (bus.alloc_idx !== 3'd4) begin
            n_bad++;
            $display("FAIL order_idx1 got=%0d exp=4", bus.alloc_idx);
        end
        tick();
        n_cmp++;
        if (bus.alloc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL order_ready got=%b exp=0", bus.alloc_ready);
        end
        for (int i = 0; i < 6; i++) begin
            set_rsp(ri[i], rc[i]);
            tick();
        end
        got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL order_line%0d got=%h exp=%h", got,
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 6 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL order_drain got=%0d valid=%b exp 6 lines then valid=0",
                     got, bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        line_t e;
        int got;
        int sl[8] = '{7, 2, 5, 0, 3, 6, 1, 4};
        apply_reset();
        set_alloc(2'b11, 8'h11);
        tick();
        set_alloc(2'b11, 8'h22);
        n_cmp++;
        if (bus.alloc_idx !== 3'd4) begin
            n_bad++;
            $display("FAIL wrap_idx1 got=%0d exp=4", bus.alloc_idx);
        end
        tick();
        n_cmp++;
        if (bus.alloc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_full got=%b exp=0", bus.alloc_ready);
        end
        for (int i = 0; i < 8; i++) begin
            set_rsp((sl[i] < 4) ? 0 : 4, sl[i] % 4);
            tick();
        end
        got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL wrap_a_line%0d got=%h exp=%h", got,
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 4 || bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL wrap_reopen got=%0d rdy=%b idx=%0d exp 4/1/0",
                     got, bus.alloc_ready, bus.alloc_idx);
        end
        set_alloc(2'b11, 8'h33);
        tick();
        for (int i = 3; i >= 0; i--) begin
            set_rsp(0, i);
            tick();
        end
        got = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL wrap_b_line%0d got=%h exp=%h", got,
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 8 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_drain got=%0d valid=%b exp 8 lines then valid=0",
                     got, bus.out_valid);
        end
    endtask

    task automatic test_stall();
        line_t e;
        int got;
        int cyc;
        apply_reset();
        set_alloc(2'b01, 8'h44);
        tick();
        set_alloc(2'b00, 8'h55);
        n_cmp++;
        if (bus.alloc_idx !== 3'd2) begin
            n_bad++;
            $display("FAIL stall_idx got=%0d exp=2", bus.alloc_idx);
        end
        tick();
        set_rsp(0, 0);
        tick();
        set_rsp(0, 1);
        tick();
        set_rsp(2, 0);
        tick();
        for (int c = 0; c < 10 && !bus.out_valid; c++) tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 ||
                {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== exp_q[0]) begin
                n_bad++;
                $display("FAIL stall_hold%0d got v=%b %h exp v=1 %h", k, bus.out_valid,
                         {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, exp_q[0]);
            end
            tick();
        end
        got = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL stall_line%0d got=%h exp=%h", got,
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 3 || cyc !== 3) begin
            n_bad++;
            $display("FAIL stall_burst got=%0d lines in %0d cycles exp 3 in 3", got, cyc);
        end
    endtask

    task automatic test_same_cycle();
        line_t e;
        int got;
        apply_reset();
        set_alloc(2'b00, 8'h61);
        tick();
        set_rsp(0, 0);
        tick();
        tick();
        set_alloc(2'b00, 8'h62);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL same_pre got=%b exp=1", bus.out_valid);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                n_bad++;
                $display("FAIL same_line0 got=%h exp=%h",
                         {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
            end
        end
        bus.out_ready = 1'b1;
        set_alloc(2'b00, 8'h63);
        n_cmp++;
        if (bus.alloc_idx !== 3'd2) begin
            n_bad++;
            $display("FAIL same_idx got=%0d exp=2", bus.alloc_idx);
        end
        set_rsp(1, 0);
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL same_gap got=%b exp=0", bus.out_valid);
        end
        set_rsp(2, 0);
        tick();
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (bus.out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.out_data, bus.out_user, bus.out_sop, bus.out_eop} !== e) begin
                    n_bad++;
                    $display("FAIL same_line%0d got=%h exp=%h", got + 1,
                             {bus.out_data, bus.out_user, bus.out_sop, bus.out_eop}, e);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got !== 2 || bus.out_valid !== 1'b0 || bus.alloc_idx !== 3'd3 ||
            bus.alloc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL same_end got=%0d v=%b idx=%0d rdy=%b exp 2/0/3/1",
                     got, bus.out_valid, bus.alloc_idx, bus.alloc_ready);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_alloc(2'b01, 8'h71);
        tick();
        set_alloc(2'b00, 8'h72);
        tick();
        set_rsp(0, 0);
        tick();
        set_rsp(0, 1);
        tick();
        set_rsp(2, 0);
        tick();
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pre got=%b exp=1", bus.out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.out_sop, bus.out_user} !== 10'd0) begin
            n_bad++;
            $display("FAIL rmid_async got v=%b sop=%b user=%h exp 0",
                     bus.out_valid, bus.out_sop, bus.out_user);
        end
        n_cmp++;
        if (bus.alloc_idx !== 3'd0 || bus.alloc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_alloc got idx=%0d rdy=%b exp 0/1",
                     bus.alloc_idx, bus.alloc_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        mtail = 0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.alloc_idx !== 3'd0 ||
            bus.alloc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_post got v=%b idx=%0d rdy=%b exp 0/0/1",
                     bus.out_valid, bus.alloc_idx, bus.alloc_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid = 1'b0;
        bus.alloc_len   = 2'b00;
        bus.alloc_user  = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_idx     = '0;
        bus.rsp_cl_num  = 2'b00;
        bus.rsp_data    = '0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_single();
        test_order();
        test_wrap();
        test_stall();
        test_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
